// File: rtl/merge_pair_if.sv
// -----------------------------------------------------------------------------
// merge_pair_if
// Handshake bundle between the run buffers / merger and merge_pair_scheduler.
// Signal names are seen from the scheduler: i_* are driven into it and o_* are
// driven by it.
//   slave  : the scheduler side (consumes i_*, drives o_*)
//   master : the environment side (drives i_*, consumes o_*)
// Signals:
//   i_src_a_empty / i_src_b_empty : per-pair source empty flags
//   i_src_a_last  / i_src_b_last  : per-pair head beat holds the run terminator
//   o_src_a_read  / o_src_b_read  : per-pair source pops
//   o_merger_a_empty / o_merger_b_empty : empties presented to the merger
//   i_merger_a_read  / i_merger_b_read  : merger pops of its two inputs
//   o_sel         : granted pair, steers the data muxes
//   i_out_write / i_out_last : merger output beat strobe and terminator flag
//   o_busy, o_run_done, o_done_pair, o_out_beats, o_err : status
// -----------------------------------------------------------------------------
interface merge_pair_if #(
  parameter int NUM_PAIRS = 4,
  parameter int SEL_W     = 2,
  parameter int CNT_W     = 16
);
  logic [NUM_PAIRS-1:0] i_src_a_empty;
  logic [NUM_PAIRS-1:0] i_src_b_empty;
  logic [NUM_PAIRS-1:0] i_src_a_last;
  logic [NUM_PAIRS-1:0] i_src_b_last;
  logic [NUM_PAIRS-1:0] o_src_a_read;
  logic [NUM_PAIRS-1:0] o_src_b_read;
  logic                 o_merger_a_empty;
  logic                 o_merger_b_empty;
  logic                 i_merger_a_read;
  logic                 i_merger_b_read;
  logic [SEL_W-1:0]     o_sel;
  logic                 i_out_write;
  logic                 i_out_last;
  logic                 o_busy;
  logic                 o_run_done;
  logic [SEL_W-1:0]     o_done_pair;
  logic [CNT_W-1:0]     o_out_beats;
  logic                 o_err;

  modport slave (
    input  i_src_a_empty, i_src_b_empty, i_src_a_last, i_src_b_last,
    input  i_merger_a_read, i_merger_b_read, i_out_write, i_out_last,
    output o_src_a_read, o_src_b_read, o_merger_a_empty, o_merger_b_empty,
    output o_sel, o_busy, o_run_done, o_done_pair, o_out_beats, o_err
  );

  modport master (
    output i_src_a_empty, i_src_b_empty, i_src_a_last, i_src_b_last,
    output i_merger_a_read, i_merger_b_read, i_out_write, i_out_last,
    input  o_src_a_read, o_src_b_read, o_merger_a_empty, o_merger_b_empty,
    input  o_sel, o_busy, o_run_done, o_done_pair, o_out_beats, o_err
  );
endinterface

// File: rtl/merge_pair_scheduler.sv
// -----------------------------------------------------------------------------
// merge_pair_scheduler
// Time-multiplexes one merger between NUM_PAIRS pairs of sorted-run sources.
// A pair is granted round-robin once both of its sources hold data; its
// empty/read handshakes are then routed to the merger's two inputs. Each side
// is fenced after its run terminator is popped so the following run cannot
// leak in. The grant is held until the merger writes its output terminator.
// Control only: the data muxes are steered by o_sel.
// Ports:
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset
//   bus    : merge_pair_if.slave handshake/status bundle (see interface file)
// -----------------------------------------------------------------------------
module merge_pair_scheduler #(
  parameter int NUM_PAIRS = 4,
  parameter int SEL_W     = 2,
  parameter int CNT_W     = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  merge_pair_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_NEXT  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SEL_W-1:0]     r_ptr;
  logic [SEL_W-1:0]     r_sel;
  logic [SEL_W-1:0]     r_done_pair;
  logic                 r_a_done;
  logic                 r_b_done;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     r_out_beats;
  logic                 r_err;
  logic                 r_run_done;

  logic [NUM_PAIRS-1:0] w_req;
  logic                 w_grant_vld;
  logic [SEL_W-1:0]     w_grant_idx;
  logic [SEL_W-1:0]     w_scan_idx;
  logic                 w_in_feed;
  logic                 w_pop_a;
  logic                 w_pop_b;
  logic                 w_term_a;
  logic                 w_term_b;
  logic                 w_bad_pop;
  logic                 w_early_last;
  logic                 w_run_end;
  logic [NUM_PAIRS-1:0] w_src_a_read;
  logic [NUM_PAIRS-1:0] w_src_b_read;
  logic                 w_merger_a_empty;
  logic                 w_merger_b_empty;
  logic                 w_busy;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  // A pop only counts when the granted side is still open; the terminator pop
  // closes that side at the next edge.
  assign w_in_feed    = (r_state == ST_FEED);
  assign w_pop_a      = w_in_feed & bus.i_merger_a_read & ~r_a_done;
  assign w_pop_b      = w_in_feed & bus.i_merger_b_read & ~r_b_done;
  assign w_term_a     = w_pop_a & bus.i_src_a_last[r_sel];
  assign w_term_b     = w_pop_b & bus.i_src_b_last[r_sel];
  // Any merger pop that is not a legal pop is a protocol error.
  assign w_bad_pop    = (bus.i_merger_a_read & ~w_pop_a) |
                        (bus.i_merger_b_read & ~w_pop_b);
  assign w_early_last = w_in_feed & bus.i_out_write & bus.i_out_last;
  assign w_run_end    = (r_state == ST_DRAIN) & bus.i_out_write & bus.i_out_last;

  // Round-robin pick: first requesting pair at or after the pointer.
  always_comb begin
    w_req       = ~bus.i_src_a_empty & ~bus.i_src_b_empty;
    w_grant_vld = 1'b0;
    w_grant_idx = {SEL_W{1'b0}};
    w_scan_idx  = {SEL_W{1'b0}};
    // Scan from the farthest offset down so the nearest requester wins last.
    for (int i = NUM_PAIRS - 1; i >= 0; i--) begin
      w_scan_idx = r_ptr + SEL_W'(i);
      if (w_req[w_scan_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_scan_idx;
      end else begin
        w_grant_vld = w_grant_vld;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_vld) begin
          w_state_nxt = ST_FEED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FEED: begin
        // Both sides closed, counting a terminator popped this very cycle.
        if ((r_a_done | w_term_a) & (r_b_done | w_term_b)) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_FEED;
        end
      end
      ST_DRAIN: begin
        if (w_run_end) begin
          w_state_nxt = ST_NEXT;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_NEXT: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: handshake routing for the granted pair and busy flag.
  always_comb begin
    w_src_a_read     = {NUM_PAIRS{1'b0}};
    w_src_b_read     = {NUM_PAIRS{1'b0}};
    w_merger_a_empty = 1'b1;
    w_merger_b_empty = 1'b1;
    w_busy           = 1'b0;
    case (r_state)
      ST_FEED: begin
        w_merger_a_empty    = bus.i_src_a_empty[r_sel] | r_a_done;
        w_merger_b_empty    = bus.i_src_b_empty[r_sel] | r_b_done;
        w_src_a_read[r_sel] = bus.i_merger_a_read & ~r_a_done;
        w_src_b_read[r_sel] = bus.i_merger_b_read & ~r_b_done;
        w_busy              = 1'b1;
      end
      ST_DRAIN: begin
        w_busy = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Grant, fence flags, beat counter, completion report and error flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr       <= {SEL_W{1'b0}};
      r_sel       <= {SEL_W{1'b0}};
      r_a_done    <= 1'b0;
      r_b_done    <= 1'b0;
      r_cnt       <= {CNT_W{1'b0}};
      r_out_beats <= {CNT_W{1'b0}};
      r_run_done  <= 1'b0;
      r_done_pair <= {SEL_W{1'b0}};
      r_err       <= 1'b0;
    end else begin
      r_run_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_vld) begin
            r_sel    <= w_grant_idx;
            r_a_done <= 1'b0;
            r_b_done <= 1'b0;
            r_cnt    <= {CNT_W{1'b0}};
          end
        end
        ST_FEED: begin
          if (w_term_a) begin
            r_a_done <= 1'b1;
          end
          if (w_term_b) begin
            r_b_done <= 1'b1;
          end
          if (bus.i_out_write) begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        ST_DRAIN: begin
          if (bus.i_out_write) begin
            r_cnt <= sat_inc(r_cnt);
          end
          // The terminator beat itself is included in the reported length.
          if (w_run_end) begin
            r_out_beats <= sat_inc(r_cnt);
            r_run_done  <= 1'b1;
            r_done_pair <= r_sel;
          end
        end
        ST_NEXT: begin
          r_ptr <= r_sel + SEL_W'(1);
        end
        default: begin
          r_ptr <= r_ptr;
        end
      endcase
      if (w_bad_pop | w_early_last) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.o_src_a_read     = w_src_a_read;
  assign bus.o_src_b_read     = w_src_b_read;
  assign bus.o_merger_a_empty = w_merger_a_empty;
  assign bus.o_merger_b_empty = w_merger_b_empty;
  assign bus.o_sel            = r_sel;
  assign bus.o_busy           = w_busy;
  assign bus.o_run_done       = r_run_done;
  assign bus.o_done_pair      = r_done_pair;
  assign bus.o_out_beats      = r_out_beats;
  assign bus.o_err            = r_err;

endmodule

// File: tb/tb_merge_pair_scheduler.sv
module tb_merge_pair_scheduler;
  localparam int NP  = 4;
  localparam int SW  = 2;
  localparam int CW  = 16;
  localparam int CW2 = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  merge_pair_if #(.NUM_PAIRS(NP), .SEL_W(SW), .CNT_W(CW))  bus ();
  merge_pair_if #(.NUM_PAIRS(NP), .SEL_W(SW), .CNT_W(CW2)) bus2 ();

  merge_pair_scheduler #(.NUM_PAIRS(NP), .SEL_W(SW), .CNT_W(CW)) u_dut (
    .i_clk(clk), .i_rst(rst), .bus(bus));
  merge_pair_scheduler #(.NUM_PAIRS(NP), .SEL_W(SW), .CNT_W(CW2)) u_dut_sat (
    .i_clk(clk), .i_rst(rst), .bus(bus2));

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {int pair; int beats;} exp_t;
  exp_t sb[$];

  // Source model: per pair, a list of beats (1 = terminator) with head/tail.
  bit a_mem[NP][64];
  bit b_mem[NP][64];
  int a_hd[NP];
  int a_tl[NP];
  int b_hd[NP];
  int b_tl[NP];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always_comb begin
    bus.i_src_a_empty = '1;
    bus.i_src_b_empty = '1;
    bus.i_src_a_last  = '0;
    bus.i_src_b_last  = '0;
    for (int i = 0; i < NP; i++) begin
      bus.i_src_a_empty[i] = (a_hd[i] == a_tl[i]);
      bus.i_src_b_empty[i] = (b_hd[i] == b_tl[i]);
      bus.i_src_a_last[i]  = a_mem[i][a_hd[i][5:0]];
      bus.i_src_b_last[i]  = b_mem[i][b_hd[i][5:0]];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (bus.o_src_a_read[i]) a_hd[i] <= a_hd[i] + 1;
      if (bus.o_src_b_read[i]) b_hd[i] <= b_hd[i] + 1;
    end
  end

  task automatic push_a(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      a_mem[p][a_tl[p]] = (k == n - 1);
      a_tl[p] = a_tl[p] + 1;
    end
  endtask

  task automatic push_b(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      b_mem[p][b_tl[p]] = (k == n - 1);
      b_tl[p] = b_tl[p] + 1;
    end
  endtask

  task automatic wait_grant(input int p);
    int t = 0;
    while (!(bus.o_busy === 1'b1 && bus.o_sel == SW'(p)) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("grant_busy", bus.o_busy, 1);
    chk("grant_sel", bus.o_sel, p);
  endtask

  // Acts as the merger: pops whatever is presented until both terminators are
  // gone, writes some beats on the way, then writes the rest ending in last.
  task automatic feed_finish(input int p, input int nout);
    int t = 0;
    int w = 0;
    bit ga = 0;
    bit gb = 0;
    bit ra;
    bit rb;
    while (!(ga && gb) && t < 2000) begin
      if (ga) chk("fence_a_empty", bus.o_merger_a_empty, 1);
      if (gb) chk("fence_b_empty", bus.o_merger_b_empty, 1);
      ra = !bus.o_merger_a_empty && ($urandom_range(0, 3) != 0);
      rb = !bus.o_merger_b_empty && ($urandom_range(0, 3) != 0);
      if (ra && bus.i_src_a_last[p]) ga = 1;
      if (rb && bus.i_src_b_last[p]) gb = 1;
      bus.i_merger_a_read = ra;
      bus.i_merger_b_read = rb;
      bus.i_out_write = (w < nout - 1) && ($urandom_range(0, 1) == 1);
      bus.i_out_last  = 1'b0;
      if (bus.i_out_write) w++;
      @(negedge clk);
      t++;
    end
    chk("terms_popped", {30'd0, ga, gb}, 3);
    bus.i_merger_a_read = 1'b0;
    bus.i_merger_b_read = 1'b0;
    while (w < nout) begin
      bus.i_out_write = 1'b1;
      bus.i_out_last  = (w == nout - 1);
      w++;
      @(negedge clk);
    end
    bus.i_out_write = 1'b0;
    bus.i_out_last  = 1'b0;
  endtask

  task automatic serve(input int p, input int nout);
    wait_grant(p);
    sb.push_back('{pair: p, beats: nout});
    feed_finish(p, nout);
  endtask

  // Monitor: completion reports against the scoreboard, gap before re-grant.
  initial begin
    exp_t e;
    int cyc = 0;
    int last_done = -100;
    logic prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.o_run_done === 1'b1) begin
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{pair: 255, beats: -1};
        chk("done_pair", bus.o_done_pair, e.pair);
        chk("out_beats", bus.o_out_beats, e.beats);
        last_done = cyc;
      end
      if (bus.o_busy === 1'b1 && prev_busy === 1'b0)
        chk("regrant_gap", (cyc - last_done) >= 2, 1);
      prev_busy = bus.o_busy;
    end
  end

  initial begin
    int exp_sat;
    int t;
    rst = 1'b0;
    bus.i_merger_a_read = 1'b0;
    bus.i_merger_b_read = 1'b0;
    bus.i_out_write = 1'b0;
    bus.i_out_last  = 1'b0;
    bus2.i_src_a_empty = '1;
    bus2.i_src_b_empty = '1;
    bus2.i_src_a_last  = '0;
    bus2.i_src_b_last  = '0;
    bus2.i_merger_a_read = 1'b0;
    bus2.i_merger_b_read = 1'b0;
    bus2.i_out_write = 1'b0;
    bus2.i_out_last  = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_a_read", bus.o_src_a_read, 0);
    chk("rst_b_read", bus.o_src_b_read, 0);
    chk("rst_a_empty", bus.o_merger_a_empty, 1);
    chk("rst_b_empty", bus.o_merger_b_empty, 1);
    chk("rst_sel", bus.o_sel, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_err", bus.o_err, 0);
    chk("rst_run_done", bus.o_run_done, 0);
    chk("rst_out_beats", bus.o_out_beats, 0);
    chk("rst_sat_beats", bus2.o_out_beats, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single pair: A=3, B=2, five output beats.
    push_a(0, 3); push_b(0, 2);
    serve(0, 5);
    chk("single_err", bus.o_err, 0);

    // Round-robin: 1 and 3 ready with pointer at 1; re-arm 1 after its run.
    push_a(1, 1); push_b(1, 3);
    push_a(3, 2); push_b(3, 4);
    serve(1, 4);
    push_a(1, 2); push_b(1, 2);
    serve(3, 6);
    serve(1, 3);

    // Fence: pair 2 A holds a 2-beat run followed by a 4-beat run.
    push_a(2, 2); push_a(2, 4); push_b(2, 3);
    serve(2, 5);
    chk("fence_left", a_tl[2] - a_hd[2], 4);
    chk("fence_err", bus.o_err, 0);

    // Simultaneous terminators: both popped together, last written next cycle.
    push_a(0, 1); push_b(0, 1);
    wait_grant(0);
    sb.push_back('{pair: 0, beats: 1});
    bus.i_merger_a_read = 1'b1;
    bus.i_merger_b_read = 1'b1;
    @(negedge clk);
    bus.i_merger_a_read = 1'b0;
    bus.i_merger_b_read = 1'b0;
    chk("sim_busy", bus.o_busy, 1);
    bus.i_out_write = 1'b1;
    bus.i_out_last  = 1'b1;
    @(negedge clk);
    bus.i_out_write = 1'b0;
    bus.i_out_last  = 1'b0;
    chk("sim_err", bus.o_err, 0);
    @(negedge clk);

    // Early terminator in FEED: error sticks, run still completes.
    push_a(1, 2); push_b(1, 1);
    wait_grant(1);
    sb.push_back('{pair: 1, beats: 3});
    bus.i_out_write = 1'b1;
    bus.i_out_last  = 1'b1;
    @(negedge clk);
    bus.i_out_write = 1'b0;
    bus.i_out_last  = 1'b0;
    chk("early_err", bus.o_err, 1);
    feed_finish(1, 2);
    @(negedge clk);
    chk("early_err_sticky", bus.o_err, 1);

    // Reset mid-run with pair 0's A side already fenced.
    push_a(0, 1); push_b(0, 3);
    wait_grant(0);
    bus.i_merger_a_read = 1'b1;
    bus.i_merger_b_read = 1'b1;
    @(negedge clk);
    chk("pre_rst_a_fenced", bus.o_merger_a_empty, 1);
    bus.i_merger_a_read = 1'b1;
    bus.i_merger_b_read = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_a_read", bus.o_src_a_read, 0);
    chk("mid_rst_b_read", bus.o_src_b_read, 0);
    chk("mid_rst_a_empty", bus.o_merger_a_empty, 1);
    chk("mid_rst_b_empty", bus.o_merger_b_empty, 1);
    chk("mid_rst_err", bus.o_err, 0);
    chk("mid_rst_sel", bus.o_sel, 0);
    chk("mid_rst_busy", bus.o_busy, 0);
    bus.i_merger_a_read = 1'b0;
    bus.i_merger_b_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    push_a(0, 1); push_b(2, 1);
    serve(0, 2);
    serve(2, 4);
    @(negedge clk);
    chk("post_rst_err", bus.o_err, 0);

    // Pop while idle: ignored, flagged.
    @(negedge clk);
    bus.i_merger_a_read = 1'b1;
    #1 chk("idle_pop_read", bus.o_src_a_read, 0);
    @(negedge clk);
    bus.i_merger_a_read = 1'b0;
    chk("idle_pop_err", bus.o_err, 1);

    // Saturation on the narrow-counter instance: 300 beats into 8 bits.
    bus2.i_src_a_empty = 4'b1110;
    bus2.i_src_b_empty = 4'b1110;
    bus2.i_src_a_last  = 4'b0001;
    bus2.i_src_b_last  = 4'b0001;
    t = 0;
    while (bus2.o_busy !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("sat_grant", bus2.o_busy, 1);
    bus2.i_merger_a_read = 1'b1;
    bus2.i_merger_b_read = 1'b1;
    @(negedge clk);
    bus2.i_merger_a_read = 1'b0;
    bus2.i_merger_b_read = 1'b0;
    bus2.i_src_a_empty = '1;
    bus2.i_src_b_empty = '1;
    for (int k = 0; k < 300; k++) begin
      bus2.i_out_write = 1'b1;
      bus2.i_out_last  = (k == 299);
      @(negedge clk);
    end
    bus2.i_out_write = 1'b0;
    bus2.i_out_last  = 1'b0;
    exp_sat = 300;
    if (exp_sat > (1 << CW2) - 1) exp_sat = (1 << CW2) - 1;
    chk("sat_done", bus2.o_run_done, 1);
    chk("sat_beats", bus2.o_out_beats, exp_sat);
    chk("sat_err", bus2.o_err, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/merge_pair_scheduler.md
Name: merge_pair_scheduler

Overview:
- Time-multiplexes one 16-wide merger between NUM_PAIRS pairs of sorted-run sources (A-side and B-side queues).
- Grants one pair at a time, round-robin. Routes that pair's empty/read handshakes to the merger's two input ports.
- Fences each run at its terminator beat so the next run cannot leak in. Holds the grant until the merger's output terminator has been written, then moves on.
- Sits between the run buffers and the merger input FIFOs. Control only; data muxing is driven by o_sel.

Parameters:
- NUM_PAIRS, 4, number of A/B source pairs sharing the merger (power of 2, ≥2).
- SEL_W, 2, width of pair index; equals log2(NUM_PAIRS).
- CNT_W, 16, width of the output beat counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_src_a_empty  in  NUM_PAIRS  per-pair A-source empty.
- i_src_b_empty  in  NUM_PAIRS  per-pair B-source empty.
- i_src_a_last  in  NUM_PAIRS  head beat of A-source contains the run terminator (all-zero element).
- i_src_b_last  in  NUM_PAIRS  same for B-source.
- o_src_a_read  out  NUM_PAIRS  pop A-source head.
- o_src_b_read  out  NUM_PAIRS  pop B-source head.
- o_merger_a_empty  out  1  presented to merger input 1 as empty.
- o_merger_b_empty  out  1  presented to merger input 2 as empty.
- i_merger_a_read  in  1  merger pops input 1.
- i_merger_b_read  in  1  merger pops input 2.
- o_sel  out  SEL_W  granted pair; drives the data muxes.
- i_out_write  in  1  merger wrote an output beat.
- i_out_last  in  1  that output beat contains the terminator.
- o_busy  out  1  a pair is granted (FEED or DRAIN).
- o_run_done  out  1  one-cycle pulse when a pair's merged run is complete.
- o_done_pair  out  SEL_W  pair index valid with o_run_done.
- o_out_beats  out  CNT_W  output beats of the last completed run.
- o_err  out  1  sticky protocol error.

Behaviour:
- **Reset** (async, any state): state=IDLE; round-robin pointer=0; o_sel=0; a_done=b_done=0; beat counter=0; o_out_beats=0; o_err=0; o_run_done=0; o_busy=0. All reads are 0, and both merger empties are 1 (combinational from state).
- **States:** IDLE, FEED, DRAIN, NEXT.
- **IDLE:**
  - A pair requests when both its A and B sources are non-empty.
  - Pick the first requesting pair at or after the pointer, wrapping modulo NUM_PAIRS.
  - Register o_sel, clear a_done/b_done/counter, go to FEED next cycle.
  - No requester: stay in IDLE.
- **FEED routing** (combinational, FEED only):
  - o_merger_a_empty = i_src_a_empty[o_sel] | a_done.
  - o_src_a_read[o_sel] = i_merger_a_read & ~a_done.
  - B side is symmetric.
  - All other bits of the read vectors are 0.
  - Outside FEED, both empties are 1 and all reads are 0.
- **Fencing:**
  - If a pop of A occurs while i_src_a_last[o_sel]=1, set a_done at the clock edge. Same for B.
  - When a_done & b_done (including both set in the same cycle), go to DRAIN.
- **Beat counter:** increments on every i_out_write in FEED or DRAIN. It saturates at all-ones and does not wrap.
- **DRAIN:** on i_out_write & i_out_last, latch o_out_beats = counter+1 (saturating), pulse o_run_done for one cycle with o_done_pair=o_sel, go to NEXT.
- **NEXT:** pointer = o_sel+1 (wraps from NUM_PAIRS-1 to 0), go to IDLE. The earliest next grant is therefore 2 cycles after the o_run_done cycle.
- **Pops in non-FEED states:** i_merger_a_read or i_merger_b_read asserted outside FEED, or after the corresponding done flag is set, sets o_err. The pop is ignored; no source is read.
- **Early terminator:** i_out_write & i_out_last in FEED, before both done flags are set, sets o_err. The FSM stays in FEED.
- **Errors:** o_err clears only on reset.
- **Source empty mid-run:** FEED stalls indefinitely with no timeout. The grant is never revoked before completion.
- **o_busy:** 1 in FEED and DRAIN.

Test Plan:
- **Single pair:** pair 0 A=3 beats, B=2 beats (last beat of each flagged last); merger pops all, writes 5 beats with last on the 5th → o_run_done pulse with o_done_pair=0, o_out_beats=5; pointer=1; no o_err.
- **Round-robin:** pairs 1 and 3 both ready, pointer 0 → grant 1 first, then 3. Re-arm pair 1 during pair 3's run → after pair 3, pair 1 is granted (wrap); gap ≥2 cycles after each o_run_done.
- **Fence:** A-source of pair 2 holds run1 terminator plus 4 beats of run2; after the terminator pops, o_merger_a_empty=1 and no further o_src_a_read[2] while B continues; the run2 beats remain in the source.
- **Simultaneous terminators:** A and B terminators popped in the same cycle → FSM enters DRAIN the next cycle. Early i_out_last injected in FEED → o_err=1 and stays 1.
- **Reset mid-run:** assert i_rst asynchronously in FEED with a_done=1 → same-cycle all reads 0, empties 1, o_err=0, o_sel=0; after release, pair 0 is granted first if ready.
- **Saturation:** force 70000 output beats with CNT_W=16 → o_out_beats=65535.
